s_mem_sequencer: RTL and testbench

//  Owns the shared S-memory port of the RC4 core; sequences init -> KSA -> PRGA.

---
 rtl/rc4_pkg.sv | 40 ++++
 rtl/phase_watchdog.sv | 38 +++
 rtl/s_mem_sequencer.sv | 128 ++++++++++++
 tb/tb_s_mem_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared types and constants for the RC4 S-memory sequencer.
//                Provides the sequencer state type, the client indices and a
//                helper that maps a phase state to its one-hot client grant.
//  Revision    : 1.0  initial release
// ============================================================================
package rc4_pkg;

    // Client slots on the shared S-memory port
    localparam int CLI_INIT = 0;
    localparam int CLI_KSA  = 1;
    localparam int CLI_PRGA = 2;
    localparam int NUM_CLI  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_KSA   = 3'd2,
        ST_PRGA  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } seq_state_t;

    // One-hot grant for a phase state; all-zero for the non-phase states
    function automatic logic [NUM_CLI-1:0] phase_onehot(input seq_state_t s);
        logic [NUM_CLI-1:0] v;
        v = '0;
        case (s)
            ST_INIT: v[CLI_INIT] = 1'b1;
            ST_KSA:  v[CLI_KSA]  = 1'b1;
            ST_PRGA: v[CLI_PRGA] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : phase_watchdog
//  Description : Per-phase cycle counter. Clears on request, counts while
//                enabled and flags the last allowed cycle of a phase.
//  Revision    : 1.0  initial release
// ============================================================================
module phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Cycle counter: clear wins, otherwise count while enabled; holds at the
    // last value so it can never wrap even if the owner ignores the timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != C_LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_timeout = i_enable && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/s_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : s_mem_sequencer
//  Description : Owns the shared S-memory port of the RC4 core. Sequences the
//                ram initializer, KSA and PRGA clients, pulsing each client's
//                start, waiting for its finished pulse and muxing exactly one
//                client onto the RAM port per phase. Stray writes from
//                non-granted clients and hung phases end in ERROR.
//  Revision    : 1.0  initial release
// ============================================================================
module s_mem_sequencer
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH      = 8,
    parameter int RAM_LENGTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic                                 abort,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    output logic [NUM_CLI-1:0]                   cli_start,
    input  logic [NUM_CLI-1:0]                   cli_finished,
    input  logic [NUM_CLI-1:0]                   cli_we,
    input  logic [NUM_CLI-1:0][RAM_LENGTH-1:0]   cli_addr,
    input  logic [NUM_CLI-1:0][RAM_WIDTH-1:0]    cli_wdata,
    output logic                                 ram_we,
    output logic [RAM_LENGTH-1:0]                ram_addr,
    output logic [RAM_WIDTH-1:0]                 ram_wdata
);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [NUM_CLI-1:0]  r_cli_start;
    logic [NUM_CLI-1:0]  w_grant;
    logic                w_busy;
    logic                w_state_change;
    logic                w_timeout;
    logic                w_finished;
    logic                w_stray;

    assign w_grant        = phase_onehot(r_state);
    assign w_busy         = |w_grant;
    assign w_finished     = |(cli_finished & w_grant);
    assign w_stray        = |(cli_we & ~w_grant);
    assign w_state_change = (w_state_next != r_state);

    // Watchdog restarts at every state change so each phase gets a full budget
    phase_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_state_change),
        .i_enable  (w_busy),
        .o_timeout (w_timeout)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; priority abort > finished > stray write > timeout
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start && !abort) begin
                    w_state_next = ST_INIT;
                end
            end
            ST_INIT, ST_KSA, ST_PRGA: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_finished) begin
                    case (r_state)
                        ST_INIT: w_state_next = ST_KSA;
                        ST_KSA:  w_state_next = ST_PRGA;
                        default: w_state_next = ST_DONE;
                    endcase
                end else if (w_stray || w_timeout) begin
                    w_state_next = ST_ERROR;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Start pulse: high only in the first cycle of the phase being entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cli_start <= '0;
        end else if (w_state_change) begin
            r_cli_start <= phase_onehot(w_state_next);
        end else begin
            r_cli_start <= '0;
        end
    end

    // Zero-latency port mux; a stray write never reaches the RAM
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        for (int i = 0; i < NUM_CLI; i++) begin
            if (w_grant[i]) begin
                ram_we    = cli_we[i];
                ram_addr  = cli_addr[i];
                ram_wdata = cli_wdata[i];
            end
        end
    end

    assign cli_start = r_cli_start;
    assign busy      = w_busy;
    assign done      = (r_state == ST_DONE);
    assign error     = (r_state == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_s_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_s_mem_sequencer
//  Description : Self-checking bench for s_mem_sequencer. Two instances share
//                the stimulus: one with the default watchdog and one with a
//                16-cycle watchdog. A phase/age reference model predicts every
//                output of both instances each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_s_mem_sequencer;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             abort;
    logic [2:0]       cli_finished;
    logic [2:0]       cli_we;
    logic [2:0][7:0]  cli_addr;
    logic [2:0][7:0]  cli_wdata;

    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0]       error;
    logic [1:0][2:0]  cli_start;
    logic [1:0]       ram_we;
    logic [1:0][7:0]  ram_addr;
    logic [1:0][7:0]  ram_wdata;

    // Model: phase code 0=idle 1=init 2=ksa 3=prga 4=done 5=error
    int m_ph  [2];
    int m_age [2];
    int m_tmo [2] = '{4096, 16};

    int n_total  = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    bit count_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    s_mem_sequencer u_dut (
        .clk (clk), .reset_n (reset_n), .start (start), .abort (abort),
        .busy (busy[0]), .done (done[0]), .error (error[0]),
        .cli_start (cli_start[0]), .cli_finished (cli_finished),
        .cli_we (cli_we), .cli_addr (cli_addr), .cli_wdata (cli_wdata),
        .ram_we (ram_we[0]), .ram_addr (ram_addr[0]), .ram_wdata (ram_wdata[0])
    );

    s_mem_sequencer #(.TIMEOUT_CYCLES (16)) u_dut_t16 (
        .clk (clk), .reset_n (reset_n), .start (start), .abort (abort),
        .busy (busy[1]), .done (done[1]), .error (error[1]),
        .cli_start (cli_start[1]), .cli_finished (cli_finished),
        .cli_we (cli_we), .cli_addr (cli_addr), .cli_wdata (cli_wdata),
        .ram_we (ram_we[1]), .ram_addr (ram_addr[1]), .ram_wdata (ram_wdata[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_of(input int k);
        return {9'b0, busy[k], done[k], error[k], cli_start[k],
                ram_we[k], ram_addr[k], ram_wdata[k]};
    endfunction

    function automatic logic [31:0] exp_of(input int k);
        int   ph;
        int   g;
        logic b;
        logic [2:0] cs;
        logic we;
        logic [7:0] ad;
        logic [7:0] wd;
        ph = m_ph[k];
        b  = (ph >= 1) && (ph <= 3);
        g  = b ? ph - 1 : 0;
        cs = (b && m_age[k] == 0) ? 3'(1 << g) : 3'b000;
        we = b ? cli_we[g]    : 1'b0;
        ad = b ? cli_addr[g]  : 8'h00;
        wd = b ? cli_wdata[g] : 8'h00;
        return {9'b0, b, (ph == 4), (ph == 5), cs, we, ad, wd};
    endfunction

    // Phase-level rules: one client granted, finished advances, abort cancels,
    // foreign write or an exhausted cycle budget fails the sequence
    task automatic model_step(input int k);
        int g;
        if (!reset_n) begin
            m_ph[k] = 0; m_age[k] = 0;
        end else if (m_ph[k] >= 1 && m_ph[k] <= 3) begin
            g = m_ph[k] - 1;
            if (abort) begin
                m_ph[k] = 0;
            end else if (cli_finished[g]) begin
                m_ph[k] = m_ph[k] + 1;
                m_age[k] = 0;
            end else if ((cli_we & ~3'(1 << g)) != 3'b000) begin
                m_ph[k] = 5;
            end else if (m_age[k] == m_tmo[k] - 1) begin
                m_ph[k] = 5;
            end else begin
                m_age[k] = m_age[k] + 1;
            end
        end else if (start && !abort) begin
            m_ph[k] = 1; m_age[k] = 0;
        end
    endtask

    // One clock: compare mid-cycle, advance the model on the edge
    task automatic tick();
        @(negedge clk);
        chk("outs_default", obs_of(0), exp_of(0));
        chk("outs_t16",     obs_of(1), exp_of(1));
        if (count_en && busy[0]) busy_cnt++;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic finish_after(input int g, input int lat);
        repeat (lat) tick();
        cli_finished = 3'(1 << g);
        tick();
        cli_finished = 3'b000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        cli_finished = '0; cli_we = '0; cli_addr = '0; cli_wdata = '0;
        m_ph = '{0, 0}; m_age = '{0, 0};

        // Reset state
        @(posedge clk); #1;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Normal run: clients finish 256/768/300 cycles after their start
        count_en = 1'b1;
        pulse_start();
        finish_after(0, 256);
        finish_after(1, 768);
        finish_after(2, 300);
        tick();
        count_en = 1'b0;
        chk("busy_cycles", 32'(busy_cnt), 32'd1327);
        chk("done_after_run", {31'b0, done[0]}, 32'd1);

        // Port mux in KSA
        pulse_start();
        finish_after(0, 2);
        cli_we = 3'b010; cli_addr[1] = 8'h5A; cli_wdata[1] = 8'hC3;
        #2;
        chk("mux_ksa", {15'b0, ram_we[0], ram_addr[0], ram_wdata[0]}, {15'b0, 1'b1, 8'h5A, 8'hC3});
        tick();
        cli_we = 3'b000;
        abort = 1'b1; tick(); abort = 1'b0;

        // Stray write in INIT
        pulse_start();
        cli_we = 3'b101;
        cli_addr[0] = 8'h11; cli_wdata[0] = 8'h22;
        cli_addr[2] = 8'h33; cli_wdata[2] = 8'h44;
        #2;
        chk("stray_mux", {15'b0, ram_we[0], ram_addr[0], ram_wdata[0]}, {15'b0, 1'b1, 8'h11, 8'h22});
        tick();
        cli_we = 3'b000;
        chk("stray_error", {30'b0, error[0], busy[0]}, 32'b10);

        // Timeout with 16-cycle watchdog: KSA never finishes
        pulse_start();
        finish_after(0, 1);
        repeat (15) tick();
        chk("t16_before", {30'b0, error[1], busy[1]}, 32'b01);
        tick();
        chk("t16_timeout", {30'b0, error[1], busy[1]}, 32'b10);
        abort = 1'b1; tick(); abort = 1'b0;
        pulse_start();
        chk("t16_restart", {27'b0, cli_start[1], error[1], busy[1]}, {27'b0, 3'b001, 1'b0, 1'b1});

        // Abort wins over finished in PRGA
        finish_after(0, 1);
        finish_after(1, 1);
        abort = 1'b1; cli_finished = 3'b100;
        tick();
        abort = 1'b0; cli_finished = 3'b000;
        chk("abort_vs_fin", {30'b0, done[0], busy[0]}, 32'b00);
        cli_we = 3'b100;
        repeat (3) tick();
        chk("abort_ram_we", {31'b0, ram_we[0]}, 32'd0);
        cli_we = 3'b000;

        // Asynchronous reset mid-KSA
        pulse_start();
        finish_after(0, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_dflt", obs_of(0), 32'd0);
        chk("async_rst_t16",  obs_of(1), 32'd0);
        m_ph = '{0, 0}; m_age = '{0, 0};
        tick(); tick();
        reset_n = 1'b1;
        tick();
        pulse_start();
        chk("after_rst_start", {28'b0, cli_start[0], busy[0]}, {28'b0, 3'b001, 1'b1});

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int g;
            g = (m_ph[0] >= 1 && m_ph[0] <= 3) ? m_ph[0] - 1 : -1;
            start        = ($urandom % 16) == 0;
            abort        = ($urandom % 64) == 0;
            cli_finished = (($urandom % 12) == 0) ? 3'(1 << ($urandom % 3)) : 3'b000;
            if (($urandom % 40) == 0)            cli_we = 3'($urandom);
            else if (g >= 0 && ($urandom % 2))   cli_we = 3'(1 << g);
            else                                 cli_we = 3'b000;
            cli_addr  = 24'($urandom);
            cli_wdata = 24'($urandom);
            tick();
        end

        start = 1'b0; abort = 1'b0; cli_finished = '0; cli_we = '0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
